// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
// SERIAL_ADDER_OVF_EN adds the registered signed-overflow flag ovf.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: done pulses WIDTH edges after an accepted start; start is ignored while busy.
// Optional SERIAL_ADDER_OVF_EN adds a signed-overflow flag captured with sum/cout.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  // Single full-adder stage; each new sum bit enters at the MSB so bit i lands at position i.
  always_comb begin
    fa_sum          = a_q[0] ^ b_q[0] ^ carry_q;
    fa_cout         = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    res_d           = res_q >> 1;
    res_d[WIDTH-1]  = fa_sum;
    last_bit        = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_cout;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            sum_q   <= res_d;
            cout_q  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q here is the carry into the MSB position.
            ovf_q   <= carry_q ^ fa_cout;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): latency, results, ignored starts, back-to-back and async reset.
module tb_serial_adder;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   lat;
  int   nbusy;
  int   done_cnt;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called just after the start edge; returns at the negedge where done is seen.
  task automatic wait_done(input string tag, output int l, output int nb);
    l  = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) return;
      if (bus.busy) nb++;
      @(posedge clk);
      l++;
    end
    chk({tag, "_timeout"}, {31'd0, bus.done}, 32'd1);
  endtask

  task automatic run_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    bus.cin   = ~ci;
    wait_done(tag, lat, nbusy);
    chk({tag, "_lat"},  lat, 32'd8);
    chk({tag, "_busy"}, nbusy, 32'd8);
    chk({tag, "_sum"},  {24'd0, bus.sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"},  {31'd0, bus.ovf}, {31'd0, eo});
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum",  {24'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf",  {31'd0, bus.ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_add("add5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_add("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_add("addff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    run_add("add0000c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

    // Start pulsed again mid-RUN with operands changing every cycle: must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_cnt  = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        chk("ign_sum",  {24'd0, bus.sum}, 32'h30);
        chk("ign_cout", {31'd0, bus.cout}, 32'd0);
      end
      if (k >= 2 && k <= 5) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF - 8'(k);
        bus.b     = 8'hFF ^ 8'(k);
        bus.cin   = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("ign_done_cnt", done_cnt, 32'd1);

    // Start held through DONE: back-to-back with no idle cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    wait_done("b2b1", lat, nbusy);
    chk("b2b1_lat",  lat, 32'd8);
    chk("b2b1_busy", nbusy, 32'd8);
    chk("b2b1_sum",  {24'd0, bus.sum}, 32'h30);
    chk("b2b1_busy_in_done", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'hEE;
    bus.b     = 8'hEE;
    @(negedge clk);
    chk("b2b_no_idle_busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b_no_idle_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    wait_done("b2b2", lat, nbusy);
    chk("b2b2_lat",  lat, 32'd7);
    chk("b2b2_sum",  {24'd0, bus.sum}, 32'h03);
    chk("b2b2_cout", {31'd0, bus.cout}, 32'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN cycle 4.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_sum",  {24'd0, bus.sum}, 32'd0);
    chk("arst_cout", {31'd0, bus.cout}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    chk("arst_quiet", done_cnt, 32'd0);
    run_add("add0101", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder that reuses the single-bit fulladder stage. It consumes the stage's sum and cout each cycle, registers the sum bit into a result shift register, and feeds cout back through a carry flop. The result is a WIDTH-bit add over WIDTH cycles with a start/busy/done handshake. It is the sequential counterpart that sits directly downstream of the fulladder and wraps it into a multi-bit datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request: capture a, b, cin and begin an add
a  input  WIDTH  operand A, sampled only on an accepted start
b  input  WIDTH  operand B, sampled only on an accepted start
cin  input  1  carry-in, sampled only on an accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when sum/cout are newly valid
sum  output  WIDTH  registered result
cout  output  1  registered carry-out of the MSB

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-add):
  - state goes to IDLE immediately; busy=0, done=0, sum=0, cout=0.
  - internal shift registers, carry flop and bit counter are cleared.
  - any in-flight add is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 loads the A/B shift registers with a/b, sets carry flop=cin and bit counter=0, then goes to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Each edge feeds A[0], B[0] and the carry flop through one fulladder instance.
  - The fulladder sum bit shifts into the result register MSB-first-in (LSB exits last), so after WIDTH shifts bit i sits at position i.
  - The fulladder cout is written to the carry flop; A and B shift right by one; the counter increments.
  - On the WIDTH-th RUN edge (E_WIDTH), the full result plus final carry are copied into sum/cout and the block goes to DONE.
- DONE:
  - done=1 for exactly one cycle; the block returns to IDLE at the next edge.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no dead cycle).
- busy=1 exactly in RUN, for WIDTH cycles after E0.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH edges after the start edge.
- start while busy=1 is ignored: no reload, and inputs are not sampled.
- a, b and cin may change freely after the start edge without affecting the result.
- sum/cout change only at the edge entering DONE. They hold their value through IDLE and RUN until the next completion; reset clears them.
- Arithmetic is unsigned: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No truncation beyond that.
- The bit counter is $clog2(WIDTH+1) bits wide. WIDTH=1 must work: one RUN cycle, then DONE.

Optional Feature:
SERIAL_ADDER_OVF_EN
- Defined:
  - adds output port ovf (1 bit), reset value 0.
  - On the final RUN edge, the carry flop value entering the MSB add is captured.
  - ovf = (carry into MSB) XOR (cout), registered alongside sum/cout, updated only at the edge entering DONE, and held otherwise.
  - ovf flags two's-complement signed overflow.
- Not defined: no ovf port and no extra logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, reset, then start with a=0x5A, b=0x33, cin=0 -> busy high 8 cycles; done pulses 8 edges after the start edge; sum=0x8D, cout=0, ovf=1 (if enabled).
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Start with 0x10+0x20. Pulse start again at RUN cycle 3 with a=0xFF, b=0xFF, and change a/b every cycle -> second start ignored; sum=0x30, cout=0; exactly one done pulse.
- Start held high through DONE with a=0x01, b=0x02 following 0x10+0x20 -> sum=0x30 at the first done; a new RUN begins with no idle cycle; second done gives sum=0x03; busy drops only during the DONE cycle.
- Start 0xAA+0x55, then assert rst_n=0 asynchronously mid-clock at RUN cycle 4 -> busy, done, sum and cout are 0 immediately; after release there is no done until a new start; then 0x01+0x01 -> sum=0x02.
